// File: rtl/key_shift_sched_if.sv
// Purpose : handshake/bus bundle between a key source, the key_shift_sched
//           block and the downstream PC-2 consumer.
// Latency : n/a (wires only).
// Backpressure: the consumer holds round values by driving ready low.
// Signals : start/key_in/ready (and decrypt when KEY_SCHED_DECRYPT_EN is
//           defined) flow into the scheduler; busy/round_valid/round_num/
//           intermediate_o/done flow out of it.
interface key_shift_sched_if;
  logic        start;
  logic [55:0] key_in;
  logic        ready;
`ifdef KEY_SCHED_DECRYPT_EN
  logic        decrypt;
`endif
  logic        busy;
  logic        round_valid;
  logic [3:0]  round_num;
  logic [55:0] intermediate_o;
  logic        done;

`ifdef KEY_SCHED_DECRYPT_EN
  modport master (
    output start, key_in, ready, decrypt,
    input  busy, round_valid, round_num, intermediate_o, done
  );
  modport slave (
    input  start, key_in, ready, decrypt,
    output busy, round_valid, round_num, intermediate_o, done
  );
`else
  modport master (
    output start, key_in, ready,
    input  busy, round_valid, round_num, intermediate_o, done
  );
  modport slave (
    input  start, key_in, ready,
    output busy, round_valid, round_num, intermediate_o, done
  );
`endif
endinterface

// File: rtl/key_shift_sched.sv
// Purpose : DES key schedule shifter; produces the 16 rotated {D,C} halves
//           that feed PC-2, one round per accepted handshake.
// Latency : round 0 valid the cycle after start is accepted; 0-cycle
//           round-to-output (intermediate_o is the state register).
// Backpressure: ready=0 freezes every output; start is ignored while busy.
//
// Ports   : clk, rst (sync active-high); bus (slave modport of
//           key_shift_sched_if): start, key_in[55:0] ({D0,C0}), ready,
//           decrypt (only with KEY_SCHED_DECRYPT_EN), busy, round_valid,
//           round_num[3:0], intermediate_o[55:0] ({D_i,C_i}), done.
// Config  : define KEY_SCHED_DECRYPT_EN to add the decrypt port and the
//           reverse (rotate-right) schedule; default build is encrypt only.
module key_shift_sched (
  input  logic              clk,
  input  logic              rst,
  key_shift_sched_if.slave  bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      r_state;
  logic [27:0] r_c;
  logic [27:0] r_d;
  logic [3:0]  r_round;
  logic        r_busy;
  logic        r_valid;
  logic        r_done;
`ifdef KEY_SCHED_DECRYPT_EN
  logic        r_dec;
`endif

  logic [3:0]  w_next_round;
  logic [27:0] w_c_load;
  logic [27:0] w_d_load;
  logic [27:0] w_c_step;
  logic [27:0] w_d_step;

  // Index 0 is DES bit 1, so a DES left rotate moves bits toward index 0:
  // new[i] = old[i+n].
  function automatic logic [27:0] rotl(input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd1:    rotl = {x[0], x[27:1]};
      2'd2:    rotl = {x[1:0], x[27:2]};
      default: rotl = x;
    endcase
  endfunction

  function automatic logic [1:0] enc_amt(input logic [3:0] rnd);
    case (rnd)
      4'd0, 4'd1, 4'd8, 4'd15: enc_amt = 2'd1;
      default:                 enc_amt = 2'd2;
    endcase
  endfunction

`ifdef KEY_SCHED_DECRYPT_EN
  // new[i] = old[i-n]
  function automatic logic [27:0] rotr(input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd1:    rotr = {x[26:0], x[27]};
      2'd2:    rotr = {x[25:0], x[27:26]};
      default: rotr = x;
    endcase
  endfunction

  // Mirror of the encrypt table: round 0 keeps the key as-is so the
  // walk starts from C16/D16 (== C0/D0) and steps backwards.
  function automatic logic [1:0] dec_amt(input logic [3:0] rnd);
    case (rnd)
      4'd0:                    dec_amt = 2'd0;
      4'd1, 4'd8, 4'd15:       dec_amt = 2'd1;
      default:                 dec_amt = 2'd2;
    endcase
  endfunction
`endif

  assign w_next_round = r_round + 4'd1;

  always_comb begin
    w_c_load = rotl(bus.key_in[27:0],  enc_amt(4'd0));
    w_d_load = rotl(bus.key_in[55:28], enc_amt(4'd0));
    w_c_step = rotl(r_c, enc_amt(w_next_round));
    w_d_step = rotl(r_d, enc_amt(w_next_round));
`ifdef KEY_SCHED_DECRYPT_EN
    // Load uses the live decrypt pin; stepping uses the mode captured at start.
    if (bus.decrypt) begin
      w_c_load = rotr(bus.key_in[27:0],  dec_amt(4'd0));
      w_d_load = rotr(bus.key_in[55:28], dec_amt(4'd0));
    end
    if (r_dec) begin
      w_c_step = rotr(r_c, dec_amt(w_next_round));
      w_d_step = rotr(r_d, dec_amt(w_next_round));
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_round <= 4'd0;
      r_c     <= 28'd0;
      r_d     <= 28'd0;
`ifdef KEY_SCHED_DECRYPT_EN
      r_dec   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          // Also reached in the done cycle, which gives back-to-back keys.
          if (bus.start) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
            r_valid <= 1'b1;
            r_round <= 4'd0;
            r_c     <= w_c_load;
            r_d     <= w_d_load;
`ifdef KEY_SCHED_DECRYPT_EN
            r_dec   <= bus.decrypt;
`endif
          end
        end
        RUN: begin
          if (bus.ready) begin
            if (r_round == 4'd15) begin
              // C/D and round_num keep their final value.
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_valid <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_round <= w_next_round;
              r_c     <= w_c_step;
              r_d     <= w_d_step;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy           = r_busy;
  assign bus.round_valid    = r_valid;
  assign bus.round_num      = r_round;
  assign bus.intermediate_o = {r_d, r_c};
  assign bus.done           = r_done;

endmodule

// File: tb/tb_key_shift_sched.sv
// Purpose : directed self-checking bench for key_shift_sched.
// Drives inputs and samples outputs on the falling clock edge.
// Define KEY_SCHED_DECRYPT_EN to include the decrypt-schedule scenario.
module tb_key_shift_sched;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  key_shift_sched_if bus ();

  key_shift_sched u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  localparam int ENC_TAB [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  logic [55:0] k1;
  logic [55:0] k2;
  logic [55:0] k1_r0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bit strings in the vectors are written index 0 first; flip into a vector.
  function automatic logic [27:0] rev28(input logic [27:0] x);
    logic [27:0] y;
    for (int i = 0; i < 28; i++) y[i] = x[27 - i];
    return y;
  endfunction

  // Reference: rotate the original key by the cumulative shift count.
  // Decrypt round r equals encrypt round 15-r.
  function automatic logic [55:0] exp_round(input logic [55:0] key, input int r, input bit dec);
    int rr;
    int cum;
    logic [27:0] c, d, nc, nd;
    rr  = dec ? 15 - r : r;
    cum = 0;
    for (int k = 0; k <= rr; k++) cum += ENC_TAB[k];
    c = key[27:0];
    d = key[55:28];
    for (int i = 0; i < 28; i++) begin
      nc[i] = c[(i + cum) % 28];
      nd[i] = d[(i + cum) % 28];
    end
    return {nd, nc};
  endfunction

  // Called on a falling edge; returns on the falling edge showing round 0.
  task automatic launch(input logic [55:0] key, input bit dec);
    bus.key_in = key;
`ifdef KEY_SCHED_DECRYPT_EN
    bus.decrypt = dec;
`endif
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("launch_dec_flag", 64'(dec), 64'(dec));
  endtask

  // Walks rounds 0..15 with optional stall, ignored start, or reset abort.
  // Returns on the falling edge where done should be high (or after abort).
  task automatic follow(input logic [55:0] key, input bit dec,
                        input int stall_at, input int poke_at, input int abort_at);
    for (int r = 0; r < 16; r++) begin
      check("round_num", 64'(bus.round_num), 64'(r));
      check("round_valid", 64'(bus.round_valid), 64'd1);
      check("busy_run", 64'(bus.busy), 64'd1);
      check("done_run", 64'(bus.done), 64'd0);
      check("inter", 64'(bus.intermediate_o), 64'(exp_round(key, r, dec)));
      if (r == stall_at) begin
        bus.ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          check("stall_round", 64'(bus.round_num), 64'(r));
          check("stall_inter", 64'(bus.intermediate_o), 64'(exp_round(key, r, dec)));
          check("stall_valid", 64'(bus.round_valid), 64'd1);
        end
        bus.ready = 1'b1;
      end
      if (r == poke_at) begin
        bus.start  = 1'b1;
        bus.key_in = k2;
      end
      if (r == abort_at) begin
        rst       = 1'b1;
        bus.start = 1'b1;
      end
      @(negedge clk);
      bus.start  = 1'b0;
      bus.key_in = key;
      if (r == abort_at) begin
        rst = 1'b0;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_valid", 64'(bus.round_valid), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        check("abort_round", 64'(bus.round_num), 64'd0);
        check("abort_inter", 64'(bus.intermediate_o), 64'd0);
        @(negedge clk);
        check("abort_done2", 64'(bus.done), 64'd0);
        check("abort_valid2", 64'(bus.round_valid), 64'd0);
        return;
      end
    end
    check("end_done", 64'(bus.done), 64'd1);
    check("end_busy", 64'(bus.busy), 64'd0);
    check("end_valid", 64'(bus.round_valid), 64'd0);
    check("end_hold", 64'(bus.intermediate_o), 64'(exp_round(key, 15, dec)));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    k1    = {rev28(28'b0101010101100110011110001111), rev28(28'b1111000011001100101010101111)};
    k1_r0 = {rev28(28'b1010101011001100111100011110), rev28(28'b1110000110011001010101011111)};
    k2    = 56'h9A3F0C71E2B548;

    // Reset with start/ready also high: reset must win.
    rst        = 1'b1;
    bus.start  = 1'b1;
    bus.ready  = 1'b1;
    bus.key_in = k1;
`ifdef KEY_SCHED_DECRYPT_EN
    bus.decrypt = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_valid", 64'(bus.round_valid), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_round", 64'(bus.round_num), 64'd0);
    check("rst_inter", 64'(bus.intermediate_o), 64'd0);
    rst       = 1'b0;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_valid", 64'(bus.round_valid), 64'd0);
    check("idle_busy", 64'(bus.busy), 64'd0);
    check("idle_done", 64'(bus.done), 64'd0);

    // Round 0 known vector, then full run with ready held high.
    launch(k1, 1'b0);
    check("t1_r0_vector", 64'(bus.intermediate_o), 64'(k1_r0));
    follow(k1, 1'b0, -1, -1, -1);
    check("t2_r15_is_key", 64'(bus.intermediate_o), 64'(k1));
    @(negedge clk);
    check("t2_done_pulse", 64'(bus.done), 64'd0);

    // Five-cycle stall at round 3.
    launch(k1, 1'b0);
    follow(k1, 1'b0, 3, -1, -1);
    @(negedge clk);
    check("t3_done_pulse", 64'(bus.done), 64'd0);

    // Start with another key at round 7 is ignored; then a back-to-back key
    // accepted in the done cycle.
    launch(k1, 1'b0);
    follow(k1, 1'b0, -1, 7, -1);
    launch(k2, 1'b0);
    follow(k2, 1'b0, -1, -1, -1);
    @(negedge clk);
    check("t4_done_pulse", 64'(bus.done), 64'd0);

    // Reset at round 9, then a clean run.
    launch(k2, 1'b0);
    follow(k2, 1'b0, -1, -1, 9);
    launch(k1, 1'b0);
    check("t5_r0_vector", 64'(bus.intermediate_o), 64'(k1_r0));
    follow(k1, 1'b0, -1, -1, -1);
    @(negedge clk);

`ifdef KEY_SCHED_DECRYPT_EN
    launch(k1, 1'b1);
    check("t6_dec_r0_is_key", 64'(bus.intermediate_o), 64'(k1));
    follow(k1, 1'b1, -1, -1, -1);
    check("t6_dec_r15_vector", 64'(bus.intermediate_o), 64'(k1_r0));
    bus.decrypt = 1'b0;
    @(negedge clk);
    launch(k2, 1'b1);
    follow(k2, 1'b1, 6, -1, -1);
    bus.decrypt = 1'b0;
    @(negedge clk);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
